// File: rtl/controller_pio_pkg.sv
// ----------------------------------------------------------------------------
// controller_pio_pkg
// Shared definitions for the pulse-capable output PIO: the Avalon-MM word
// offsets of the register map and the pulse state encoding.
// ----------------------------------------------------------------------------
package controller_pio_pkg;

    // Register map, word addresses on the 3-bit Avalon address bus
    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_SET    = 3'd1;
    localparam logic [2:0] REG_CLEAR  = 3'd2;
    localparam logic [2:0] REG_PULSE  = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;
    localparam logic [2:0] REG_PLEN   = 3'd5;

    // Pulse timer state
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } pulse_state_e;

endpackage

// File: rtl/controller_pulse_timer.sv
// ----------------------------------------------------------------------------
// controller_pulse_timer
// Down-counter that keeps a pulse active for load_val cycles after a load.
// A load while already active restarts the count (retrigger).
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous active-high reset
//   load      in   start / retrigger the pulse this cycle
//   load_val  in   pulse length in cycles (must be nonzero)
//   expire    out  last active cycle with no retrigger; pulse ends at this edge
//   active    out  pulse in progress (registered state)
// ----------------------------------------------------------------------------
module controller_pulse_timer
    import controller_pio_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire,
    output logic             active
);

    pulse_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        state_q <= ACTIVE;
                        cnt_q   <= load_val;
                    end
                end
                ACTIVE: begin
                    // A retrigger takes priority over expiry in the same cycle
                    if (load) begin
                        cnt_q <= load_val;
                    end else if (cnt_q == CNT_W'(1)) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign active = (state_q == ACTIVE);
    assign expire = active && (cnt_q == CNT_W'(1)) && !load;

endmodule

// File: rtl/controller_pulse_pio.sv
// ----------------------------------------------------------------------------
// controller_pulse_pio
// Avalon-MM output PIO with atomic set/clear and a timed pulse mode. Bits
// selected by a PULSE write are held at PULSE_LEVEL for pulse_len cycles and
// then fall back to data_reg.
//
// Ports:
//   clk         in   system clock
//   reset       in   synchronous active-high reset
//   address     in   word address (see controller_pio_pkg)
//   chipselect  in   slave select
//   write_n     in   active-low write strobe
//   writedata   in   write data
//   readdata    out  zero-wait-state read data, zero-extended
//   out_port    out  output bits
//   pulse_busy  out  pulse in progress (STATUS[0])
// ----------------------------------------------------------------------------
module controller_pulse_pio
    import controller_pio_pkg::*;
#(
    parameter int               WIDTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = 2'b11,
    parameter logic             PULSE_LEVEL = 1'b1,
    parameter int               CNT_W       = 16,
    parameter logic [CNT_W-1:0] PULSE_DEF   = 16'd8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             pulse_busy
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [CNT_W-1:0] plen_q, plen_d;

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [CNT_W-1:0] wd_len;
    logic             timer_load;
    logic             timer_expire;
    logic             timer_active;
    logic [WIDTH-1:0] mask_eff;

    // Upper writedata bits are unused when WIDTH and CNT_W are below 32
    logic unused_wd;
    assign unused_wd = ^writedata;

    assign wr     = chipselect & ~write_n;
    assign wd     = writedata[WIDTH-1:0];
    assign wd_len = writedata[CNT_W-1:0];

    // A zero-mask PULSE write only matters as a retrigger of a running pulse
    assign timer_load = wr && (address == REG_PULSE) && (timer_active || (wd != '0));

    controller_pulse_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (plen_q),
        .expire   (timer_expire),
        .active   (timer_active)
    );

    // NOTE: every next-state variable gets its hold value first so no path
    // through the block leaves it unassigned, which would infer a latch.
    always_comb begin
        data_d = data_q;
        mask_d = mask_q;
        plen_d = plen_q;

        if (wr) begin
            case (address)
                REG_DATA:  data_d = wd;
                REG_SET:   data_d = data_q | wd;
                REG_CLEAR: data_d = data_q & ~wd;
                REG_PLEN:  plen_d = (wd_len == '0) ? CNT_W'(1) : wd_len;
                default:   ;
            endcase
        end

        if (timer_load) begin
            mask_d = (timer_active ? mask_q : '0) | wd;
        end else if (timer_expire) begin
            mask_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= RESET_VALUE;
            mask_q <= '0;
            plen_q <= PULSE_DEF;
        end else begin
            data_q <= data_d;
            mask_q <= mask_d;
            plen_q <= plen_d;
        end
    end

    assign mask_eff   = timer_active ? mask_q : '0;
    assign out_port   = (data_q & ~mask_eff) | ({WIDTH{PULSE_LEVEL}} & mask_eff);
    assign pulse_busy = timer_active;

    always_comb begin
        readdata = '0;
        case (address)
            REG_DATA:   readdata[WIDTH-1:0] = data_q;
            REG_PULSE:  readdata[WIDTH-1:0] = mask_eff;
            REG_STATUS: readdata[0]         = timer_active;
            REG_PLEN:   readdata[CNT_W-1:0] = plen_q;
            default:    ;
        endcase
    end

endmodule

// File: tb/tb_controller_pulse_pio.sv
// ----------------------------------------------------------------------------
// tb_controller_pulse_pio
// Directed scenarios followed by random bus traffic against a reference
// model that tracks data, pulse length, pulse mask and remaining pulse cycles.
// ----------------------------------------------------------------------------
module tb_controller_pulse_pio;

    localparam logic [1:0] RV  = 2'b11;
    localparam logic       PL  = 1'b1;
    localparam int         DEF = 8;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  out_port;
    logic        pulse_busy;

    int vectors;
    int miscompares;

    // Reference model state
    logic [1:0] m_data;
    logic [1:0] m_mask;
    int         m_plen;
    int         m_rem;   // forced cycles still to come, 0 when idle

    // Samples of the last cycle
    logic [31:0] s_rd;
    logic [1:0]  s_out;
    logic        s_busy;

    controller_pulse_pio dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .pulse_busy (pulse_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] addr);
        case (addr)
            3'd0:    return {30'd0, m_data};
            3'd3:    return {30'd0, m_mask};
            3'd4:    return {31'd0, (m_rem > 0)};
            3'd5:    return 32'(m_plen);
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_step(input logic rst, input logic cs, input logic wn,
                                       input logic [2:0] addr, input logic [31:0] wd);
        logic       wr;
        logic [1:0] w2;
        if (rst) begin
            m_data = RV;
            m_plen = DEF;
            m_mask = 2'b00;
            m_rem  = 0;
            return;
        end
        wr = cs & ~wn;
        w2 = wd[1:0];
        if (wr) begin
            case (addr)
                3'd0: m_data = w2;
                3'd1: m_data = m_data | w2;
                3'd2: m_data = m_data & ~w2;
                3'd5: m_plen = (wd[15:0] == 16'd0) ? 1 : int'(wd[15:0]);
                default: ;
            endcase
        end
        if (wr && addr == 3'd3 && (m_rem > 0 || w2 != 2'b00)) begin
            m_mask = ((m_rem > 0) ? m_mask : 2'b00) | w2;
            m_rem  = m_plen;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) m_mask = 2'b00;
        end
    endfunction

    function automatic logic [1:0] model_out();
        return (m_data & ~m_mask) | (PL ? m_mask : 2'b00);
    endfunction

    // One bus cycle: drive on the falling edge, check read data before the
    // rising edge, advance the model at the edge, check outputs #1 after it.
    task automatic do_cycle(input logic rst, input logic cs, input logic wn,
                            input logic [2:0] addr, input logic [31:0] wd);
        @(negedge clk);
        reset      = rst;
        chipselect = cs;
        write_n    = wn;
        address    = addr;
        writedata  = wd;
        #1;
        s_rd = readdata;
        check($sformatf("readdata@%0d", addr), readdata, model_read(addr));
        @(posedge clk);
        model_step(rst, cs, wn, addr, wd);
        #1;
        s_out  = out_port;
        s_busy = pulse_busy;
        check("out_port", {30'd0, out_port}, {30'd0, model_out()});
        check("pulse_busy", {31'd0, pulse_busy}, {31'd0, (m_rem > 0)});
    endtask

    task automatic wr_reg(input logic [2:0] addr, input logic [31:0] wd);
        do_cycle(1'b0, 1'b1, 1'b0, addr, wd);
    endtask

    task automatic rd_reg(input logic [2:0] addr);
        do_cycle(1'b0, 1'b1, 1'b1, addr, 32'd0);
    endtask

    task automatic idle();
        do_cycle(1'b0, 1'b0, 1'b1, 3'd0, 32'd0);
    endtask

    // Keep idling while busy, counting busy samples (bounded)
    task automatic drain(inout int n);
        for (int i = 0; i < 40 && s_busy; i++) begin
            idle();
            if (s_busy) n++;
        end
    endtask

    initial begin
        int n;
        logic [2:0]  a;
        logic [31:0] d;
        vectors     = 0;
        miscompares = 0;
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'd0;
        repeat (2) @(posedge clk);
        model_step(1'b1, 1'b0, 1'b1, 3'd0, 32'd0);

        // 1. Reset state
        rd_reg(3'd0);
        check("t1 data", s_rd, 32'd3);
        check("t1 out", {30'd0, s_out}, 32'd3);
        rd_reg(3'd4);
        check("t1 status", s_rd, 32'd0);
        rd_reg(3'd5);
        check("t1 plen", s_rd, 32'd8);

        // 2. DATA / SET / CLEAR
        wr_reg(3'd0, 32'd0);
        check("t2 data0", {30'd0, s_out}, 32'd0);
        wr_reg(3'd1, 32'd1);
        check("t2 set", {30'd0, s_out}, 32'd1);
        wr_reg(3'd2, 32'd1);
        check("t2 clear", {30'd0, s_out}, 32'd0);

        // 3. Five-cycle pulse
        wr_reg(3'd5, 32'd5);
        wr_reg(3'd3, 32'd2);
        check("t3 out", {30'd0, s_out}, 32'd2);
        n = s_busy ? 1 : 0;
        drain(n);
        check("t3 busy cycles", 32'(n), 32'd5);
        check("t3 released", {30'd0, s_out}, 32'd0);

        // 4. Retrigger on the last active cycle
        wr_reg(3'd5, 32'd4);
        wr_reg(3'd3, 32'd1);
        n = s_busy ? 1 : 0;
        repeat (3) begin
            idle();
            if (s_busy) n++;
        end
        wr_reg(3'd3, 32'd2);
        if (s_busy) n++;
        check("t4 merged mask", {30'd0, s_out}, 32'd3);
        drain(n);
        check("t4 busy cycles", 32'(n), 32'd8);

        // 5. PLEN of zero, zero-mask pulse
        wr_reg(3'd5, 32'd0);
        rd_reg(3'd5);
        check("t5 plen", s_rd, 32'd1);
        wr_reg(3'd3, 32'd1);
        n = s_busy ? 1 : 0;
        drain(n);
        check("t5 busy cycles", 32'(n), 32'd1);
        wr_reg(3'd3, 32'd0);
        check("t5 zero mask", {31'd0, s_busy}, 32'd0);
        idle();

        // 6. Reset mid-pulse, then a clean pulse with default length
        wr_reg(3'd0, 32'd0);
        wr_reg(3'd5, 32'd6);
        wr_reg(3'd3, 32'd3);
        idle();
        idle();
        do_cycle(1'b1, 1'b0, 1'b1, 3'd0, 32'd0);
        check("t6 out", {30'd0, s_out}, 32'd3);
        check("t6 busy", {31'd0, s_busy}, 32'd0);
        wr_reg(3'd0, 32'd0);
        wr_reg(3'd3, 32'd1);
        n = s_busy ? 1 : 0;
        drain(n);
        check("t6 busy cycles", 32'(n), 32'd8);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            a = 3'($urandom_range(0, 7));
            d = $urandom();
            if (a == 3'd5) d = 32'($urandom_range(0, 6));
            if ($urandom_range(0, 63) == 0)
                do_cycle(1'b1, 1'b0, 1'b1, a, d);
            else
                do_cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
